// File: rtl/alu_issue.sv
// Issue/writeback controller for the alu block: registers one request, holds it on
// the ALU operand interface until alu_valid or watchdog expiry, then returns the result.
module alu_issue #(
  parameter int N            = 32,
  parameter int WIDTH_OPCODE = 4,
  parameter int TAG_W        = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH_OPCODE-1:0] in_opcode,
  input  logic [N-1:0]            in_a,
  input  logic [N-1:0]            in_b,
  input  logic [N-1:0]            in_imm,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    enable_alu,
  output logic [WIDTH_OPCODE-1:0] opcode,
  output logic [N-1:0]            dataA,
  output logic [N-1:0]            dataB,
  output logic [N-1:0]            data_imm,
  input  logic                    alu_valid,
  input  logic                    alu_zero,
  input  logic [N-1:0]            alu_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N-1:0]            out_data,
  output logic                    out_zero,
  output logic [1:0]              out_err,
  output logic [TAG_W-1:0]        out_tag,
  output logic [15:0]             ok_count,
  output logic [15:0]             err_count
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [WD_W-1:0]         r_wd;
  logic                    r_enable;
  logic [WIDTH_OPCODE-1:0] r_opcode;
  logic [N-1:0]            r_a;
  logic [N-1:0]            r_b;
  logic [N-1:0]            r_imm;
  logic                    r_out_valid;
  logic [N-1:0]            r_out_data;
  logic                    r_out_zero;
  logic [1:0]              r_out_err;
  logic [TAG_W-1:0]        r_out_tag;
  logic [15:0]             r_ok_count;
  logic [15:0]             r_err_count;

  logic                    w_legal;
  logic                    w_accept;
  logic                    w_capture;
  logic                    w_timeout;
  logic                    w_handshake;

  always_comb begin
    w_legal = 1'b0;
    case (in_opcode)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0101, 4'b0110, 4'b1001, 4'b1011: w_legal = 1'b1;
      default:                            w_legal = 1'b0;
    endcase
  end

  assign in_ready = (r_state == S_IDLE) && !rst;

  // alu_valid is checked before the watchdog so a result on the final cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_capture   = 1'b0;
    w_timeout   = 1'b0;
    w_handshake = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = w_legal ? S_EXEC : S_RESP;
        end
      end
      S_EXEC: begin
        if (alu_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = S_RESP;
        end else if (r_wd == WD_W'(TIMEOUT - 1)) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          w_handshake = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wd        <= '0;
      r_enable    <= 1'b0;
      r_opcode    <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_imm       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_zero  <= 1'b0;
      r_out_err   <= '0;
      r_out_tag   <= '0;
      r_ok_count  <= '0;
      r_err_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_enable    <= (w_state_nxt == S_EXEC);
      r_out_valid <= (w_state_nxt == S_RESP);

      if (w_accept) begin
        r_opcode  <= in_opcode;
        r_a       <= in_a;
        r_b       <= in_b;
        r_imm     <= in_imm;
        r_out_tag <= in_tag;
        r_wd      <= '0;
        if (!w_legal) begin
          r_out_data <= '0;
          r_out_zero <= 1'b0;
          r_out_err  <= 2'd1;
        end
      end else if (r_state == S_EXEC) begin
        r_wd <= r_wd + WD_W'(1);
      end

      if (w_capture) begin
        r_out_data <= alu_data;
        r_out_zero <= alu_zero;
        r_out_err  <= 2'd0;
      end else if (w_timeout) begin
        r_out_data <= '0;
        r_out_zero <= 1'b0;
        r_out_err  <= 2'd2;
      end

      if (w_handshake) begin
        if (r_out_err == 2'd0) r_ok_count  <= r_ok_count + 16'd1;
        else                   r_err_count <= r_err_count + 16'd1;
      end
    end
  end

  assign enable_alu = r_enable;
  assign opcode     = r_opcode;
  assign dataA      = r_a;
  assign dataB      = r_b;
  assign data_imm   = r_imm;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_zero   = r_out_zero;
  assign out_err    = r_out_err;
  assign out_tag    = r_out_tag;
  assign ok_count   = r_ok_count;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU stub of configurable latency.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_opcode = '0;
  logic [31:0] in_a = '0, in_b = '0, in_imm = '0;
  logic [3:0]  in_tag = '0;
  logic        enable_alu;
  logic [3:0]  opcode;
  logic [31:0] dataA, dataB, data_imm;
  logic        alu_valid;
  logic        alu_zero;
  logic [31:0] alu_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_zero;
  logic [1:0]  out_err;
  logic [3:0]  out_tag;
  logic [15:0] ok_count, err_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Stub: alu_valid in the lat-th cycle of enable_alu (lat = 0 means never).
  int stub_lat = 1;
  int stub_cnt = 0;
  logic [63:0] w_prod;

  always #5 clk = ~clk;

  alu_issue #(.N(32), .WIDTH_OPCODE(4), .TAG_W(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_tag(in_tag),
    .enable_alu(enable_alu), .opcode(opcode), .dataA(dataA), .dataB(dataB),
    .data_imm(data_imm), .alu_valid(alu_valid), .alu_zero(alu_zero),
    .alu_data(alu_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_zero(out_zero), .out_err(out_err),
    .out_tag(out_tag), .ok_count(ok_count), .err_count(err_count)
  );

  always @(posedge clk) begin
    if (!enable_alu) stub_cnt <= 0;
    else             stub_cnt <= stub_cnt + 1;
  end

  assign alu_valid = enable_alu && (stub_lat != 0) && (stub_cnt == stub_lat - 1);
  assign w_prod    = {32'd0, dataA} * {32'd0, dataB};

  always_comb begin
    case (opcode)
      4'b0000: alu_data = dataA + dataB;
      4'b1001: alu_data = dataA - dataB;
      4'b0110: alu_data = dataA + data_imm;
      4'b0100: alu_data = w_prod[47:16];
      default: alu_data = 32'hDEAD_BEEF;
    endcase
  end
  assign alu_zero = (alu_data == 32'd0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the response handshake.
  task automatic run_op(input string name, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] imm,
                        input logic [3:0] tag, input int lat,
                        input int exp_cyc, input int exp_en,
                        input logic [31:0] exp_data, input logic exp_z,
                        input logic [1:0] exp_err, input int hold);
    int cyc;
    int en;
    logic bad;
    logic [37:0] snap;
    stub_lat  = lat;
    in_opcode = op; in_a = a; in_b = b; in_imm = imm; in_tag = tag;
    in_valid  = 1'b1;
    check({name, "_in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1; en = 0; bad = 1'b0;
    while (!out_valid && cyc < 200) begin
      if (enable_alu) begin
        en++;
        if (opcode !== op || dataA !== a || dataB !== b || data_imm !== imm) bad = 1'b1;
      end
      if (in_ready) bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check({name, "_latency"}, cyc, exp_cyc);
    check({name, "_en_cycles"}, en, exp_en);
    check({name, "_stable"}, bad, 1'b0);
    check({name, "_en_off"}, enable_alu, 1'b0);
    check({name, "_data"}, out_data, exp_data);
    check({name, "_zero"}, out_zero, exp_z);
    check({name, "_err"}, out_err, exp_err);
    check({name, "_tag"}, out_tag, tag);
    if (hold > 0) begin
      snap = {out_data, out_zero, out_err, out_tag};
      bad  = 1'b0;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (!out_valid || in_ready || enable_alu ||
            {out_data, out_zero, out_err, out_tag} !== snap) bad = 1'b1;
      end
      check({name, "_hold"}, bad, 1'b0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({name, "_resp_drop"}, out_valid, 1'b0);
    check({name, "_ready_back"}, in_ready, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_outs", {enable_alu, opcode, dataA, dataB, data_imm, out_valid,
                       out_data, out_zero, out_err, out_tag} == '0, 1'b1);
    check("rst_counts", {ok_count, err_count}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rel_in_ready", in_ready, 1'b1);

    run_op("add", 4'b0000, 32'd5, 32'd7, 32'd0, 4'd3, 1, 2, 1, 32'd12, 1'b0, 2'd0, 0);
    check("add_ok", ok_count, 16'd1);

    run_op("sub", 4'b1001, 32'h0003_0000, 32'h0003_0000, 32'd0, 4'd4, 1, 2, 1,
           32'd0, 1'b1, 2'd0, 0);
    run_op("addi", 4'b0110, 32'd1, 32'd0, 32'hFFFF_FFFF, 4'd5, 1, 2, 1,
           32'd0, 1'b1, 2'd0, 0);
    check("b2b_ok", ok_count, 16'd3);

    run_op("mul", 4'b0100, 32'h0002_0000, 32'h0003_0000, 32'd9, 4'd6, 5, 6, 5,
           32'h0006_0000, 1'b0, 2'd0, 0);

    run_op("ill", 4'b0111, 32'd1, 32'd2, 32'd3, 4'd7, 1, 1, 0, 32'd0, 1'b0, 2'd1, 0);
    check("ill_err_cnt", err_count, 16'd1);

    run_op("tmo", 4'b0101, 32'd100, 32'd3, 32'd0, 4'd8, 0, 65, 64, 32'd0, 1'b0, 2'd2, 0);
    check("tmo_err_cnt", err_count, 16'd2);

    run_op("last", 4'b0101, 32'd100, 32'd3, 32'd0, 4'd9, 64, 65, 64,
           32'hDEAD_BEEF, 1'b0, 2'd0, 0);

    run_op("hold", 4'b0000, 32'd100, 32'd23, 32'd0, 4'hA, 1, 2, 1, 32'd123, 1'b0, 2'd0, 10);
    check("ok_cnt", ok_count, 16'd6);
    check("err_cnt", err_count, 16'd2);

    stub_lat  = 0;
    in_opcode = 4'b0101; in_a = 32'd1; in_b = 32'd1; in_tag = 4'hB;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_en", enable_alu, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_en", enable_alu, 1'b0);
    check("mid_rst_ov", out_valid, 1'b0);
    check("mid_rst_rdy", in_ready, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rel_rdy", in_ready, 1'b1);
    repeat (5) @(negedge clk);
    check("mid_no_resp", {out_valid, enable_alu}, 2'b00);
    check("mid_counts", {ok_count, err_count}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Issue and writeback controller that drives the `alu` block's operand interface from the instruction-sequencing side. It accepts one operation at a time over a valid/ready handshake, registers the operands, and holds `enable_alu`, `opcode` and the operands stable until the ALU reports `valid`. This covers both single-cycle ops and the multi-cycle multiply and divide units. It then returns the result, zero flag and tag over a second valid/ready handshake, with illegal-opcode detection and a watchdog timeout.

## Interface
- `N`, 32, data width; must match the ALU's `N`
- `WIDTH_OPCODE`, 4, opcode width; must match the ALU
- `TAG_W`, 4, width of the caller's transaction tag
- `TIMEOUT`, 64, maximum number of EXEC cycles allowed without `alu_valid`; legal range is ≥2
- `clk` in 1: the single clock
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: request valid
- `in_ready` out 1: request accept; high only in IDLE and while `rst` is low
- `in_opcode` in WIDTH_OPCODE: requested operation
- `in_a`, `in_b`, `in_imm` in N: operands A and B, and the immediate
- `in_tag` in TAG_W: transaction tag, returned unchanged on `out_tag`
- `enable_alu` out 1: ALU enable; registered
- `opcode` out WIDTH_OPCODE, `dataA` / `dataB` / `data_imm` out N: registered operands to the ALU
- `alu_valid` in 1: ALU result valid; may be combinational in the same cycle as `enable_alu`
- `alu_zero` in 1: ALU zero flag
- `alu_data` in N: ALU result
- `out_valid` out 1: response valid
- `out_ready` in 1: response accept
- `out_data` out N: captured result
- `out_zero` out 1: captured zero flag
- `out_err` out 2: 0 = ok, 1 = illegal opcode, 2 = timeout
- `out_tag` out TAG_W: tag of the returned transaction
- `ok_count` out 16, `err_count` out 16: completed-response counters

## Operation
- State machine: IDLE, EXEC, RESP.
- IDLE:
  - `in_valid & in_ready` registers the opcode, operands and tag.
  - Legal opcode → EXEC. Legal set: 0000, 0001, 0010, 0011, 0100, 0101, 0110, 1001, 1011.
  - Any other opcode → RESP directly with `out_err`=1, `out_data`=0, `out_zero`=0. `enable_alu` is never asserted for it.
- EXEC:
  - `enable_alu`=1; `opcode`/`dataA`/`dataB`/`data_imm` are held constant for the whole state.
  - The watchdog counter clears on entry and increments each EXEC cycle.
  - `alu_valid` sampled high → capture `alu_data` and `alu_zero`, set `out_err`=0, go to RESP.
  - Watchdog reaches `TIMEOUT` with no `alu_valid` → go to RESP with `out_err`=2, `out_data`=0, `out_zero`=0.
  - If `alu_valid` and the timeout occur in the same cycle, `alu_valid` wins (`out_err`=0).
- RESP:
  - `enable_alu`=0; `out_valid`=1; `out_data`, `out_zero`, `out_err` and `out_tag` are held stable until `out_ready`.
  - The `out_valid & out_ready` handshake returns the FSM to IDLE.
  - That same handshake increments `ok_count` if `out_err`=0, otherwise `err_count`.
  - Both counters wrap from 0xFFFF to 0.
- Only one operation is outstanding at a time. `in_ready`=0 in EXEC and RESP.
- `enable_alu` is held for the whole of a multi-cycle op (opcodes 0100 and 0101) so the ALU's result mux stays routed to the unit. The unit's start behaviour under a held enable is the unit's responsibility.
- `alu_zero` and `alu_data` are ignored except in the capture cycle.
- Operands pass through unmodified: no sign extension or truncation.

## Timing
- Reset (synchronous, `rst`=1 at a clock edge):
  - State → IDLE.
  - All outputs → 0: `enable_alu`, `opcode`, `dataA`, `dataB`, `data_imm`, `out_valid`, `out_data`, `out_zero`, `out_err`, `out_tag`, `ok_count`, `err_count`.
  - `in_ready`=0 while `rst`=1, and 1 in the first cycle after release.
- Reset mid-EXEC or mid-RESP: the operation is aborted. `enable_alu` and `out_valid` are low after the reset edge, no response is emitted, and no counter is updated.
- Latency, with the request accepted at edge T:
  - `enable_alu` is high from T+1.
  - Single-cycle op: `alu_valid` is seen in cycle T+1, and `out_valid` is high from T+2.
  - Multi-cycle op: `out_valid` rises the cycle after the first `alu_valid`.
  - Illegal opcode: `out_valid` is high from T+1.
  - Timeout: `out_valid` is high `TIMEOUT`+1 cycles after T.
- Back-to-back throughput: a new request is accepted in the cycle after the `out_valid & out_ready` handshake. The minimum is one operation per 3 cycles.
- `in_ready` is combinational from state and `rst`; all other outputs are registered.

## Test plan
- Add 0000, A=5, B=7, tag=3 → `enable_alu` high exactly 1 cycle; `out_valid` at T+2; `out_data`=12, `out_zero`=0, `out_err`=0, `out_tag`=3; `ok_count`=1.
- Subtract 1001, A=B=0x00030000 → `out_data`=0, `out_zero`=1. Back-to-back with add 0110 A=1, imm=0xFFFFFFFF → `out_data`=0, `out_zero`=1, second request accepted the cycle after the first response handshake.
- Multiply 0100, A=0x00020000, B=0x00030000, with a stub that asserts `alu_valid` 5 cycles after enable → operands held stable all 5 cycles; `out_data`=0x00060000; `out_valid` the cycle after `alu_valid`.
- Illegal 0111 → `enable_alu` never high; `out_valid` at T+1 with `out_err`=1, `out_data`=0; `err_count`=1.
- Divide 0101 with a stub never asserting valid, `TIMEOUT`=64 → `enable_alu` high 64 cycles then low; `out_err`=2. A second run with valid on cycle 64 itself → `out_err`=0.
- `out_ready` held low 10 cycles in RESP → outputs stable, `in_ready`=0. Separately, `rst` pulsed during EXEC → no response, counters unchanged, `in_ready`=1 after release.
